dmem_refill_ctrl: RTL
=====================

# dmem_refill_ctrl

Data-memory access controller that sits directly upstream of the direct-mapped cached data memory, between the pipeline memory stage and the cache/main-memory pair. It serves read hits in zero extra cycles and stalls the pipeline on read misses and all stores. It sequences a handshaked main-memory access for each miss or store, then fills the cache on word read misses. Stores are write-through, no-allocate. Hit/miss performance counters are included.

## Interface
- DATA_WIDTH, 32, data and address width
- CNT_WIDTH, 32, width of each performance counter

- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  memory-stage access present
- req_we  in  1  1 = store, 0 = load
- req_type  in  1  MemType: 0 = word, 1 = byte
- req_addr  in  DATA_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data
- stall_o  out  1  freeze pipeline; request inputs held stable while high
- rdata_o  out  DATA_WIDTH  load result
- rdata_valid  out  1  rdata_o valid this cycle
- cache_hit  in  1  cache lookup result for req_addr
- cache_data  in  DATA_WIDTH  cached word for req_addr
- cache_fill  out  1  write cache_fill_data into line for cache_fill_addr
- cache_inval  out  1  invalidate line for cache_fill_addr
- cache_fill_addr  out  DATA_WIDTH  line address for fill/invalidate
- cache_fill_data  out  DATA_WIDTH  fill word
- mem_req  out  1  main-memory request, held until mem_ready
- mem_we, mem_type  out  1 each  store flag and MemType to memory
- mem_addr, mem_wdata  out  DATA_WIDTH  registered request address and data
- mem_rdata  in  DATA_WIDTH  memory read data, valid with mem_ready
- mem_ready  in  1  memory completes the current request this cycle
- hit_count, miss_count  out  CNT_WIDTH  load hits / load misses since reset

## Operation
- States: IDLE, MEM_READ, FILL, MEM_WRITE.
- IDLE, no req_valid: all outputs low.
- IDLE, load, cache_hit=1: rdata_o=cache_data, rdata_valid=1, stall_o=0, hit_count+1. Remain in IDLE.
- IDLE, load, cache_hit=0: stall_o=1 combinationally, latch request, miss_count+1, go to MEM_READ.
- IDLE, store: stall_o=1 and latch request. If cache_hit, pulse cache_inval with cache_fill_addr=req_addr. Go to MEM_WRITE.
- MEM_READ: mem_req=1, stall_o=1. On mem_ready, capture mem_rdata and go to FILL.
- FILL, one cycle: rdata_o=captured data, rdata_valid=1, stall_o=0, go to IDLE.
  - cache_fill=1 only if latched type=word and addr[1:0]==0.
  - Byte loads and misaligned words are never filled. They still count as misses.
- MEM_WRITE: mem_req=1, mem_we=1. stall_o=1 except in the mem_ready cycle, where stall_o=0 and the next state is IDLE.
- mem_* outputs come from latched registers, stable for the whole request. mem_req is never asserted in IDLE or FILL.
- Counters wrap modulo 2^CNT_WIDTH. Stores do not count.
- Reset (any time, including mid-access): state=IDLE, all outputs 0, counters 0, latched request cleared. mem_req drops immediately (asynchronous).

## Timing
- Load hit latency: 0 cycles (same-cycle result, no stall).
- Load miss: stall cycles = 1 (IDLE detect) + N memory-wait cycles, where N counts MEM_READ cycles up to and including mem_ready. The result appears in FILL, exactly one cycle after the mem_ready cycle.
- mem_ready already high on the first MEM_READ cycle: load miss takes 3 cycles total (IDLE, MEM_READ, FILL).
- Store: pipeline released in the mem_ready cycle. Minimum 2 cycles (IDLE, MEM_WRITE).
- Back-to-back requests:
  - A new request is accepted in the first IDLE cycle after FILL, or after the mem_ready cycle of MEM_WRITE.
  - FILL does not accept a new request. The pipeline advances there, so the next access arrives in the following cycle.
- mem_ready outside MEM_READ/MEM_WRITE is ignored.

## Structure
- Shared package dmem_pkg: state enum (IDLE, MEM_READ, FILL, MEM_WRITE), MEM_WORD=1'b0, MEM_BYTE=1'b1.
- One natural sub-module, perf_counter: wrapping counter with enable and async reset, instantiated twice.

## Test plan
- Load word 0x0000_0010, cache_hit=1, cache_data=0xDEAD_BEEF -> same cycle rdata_o=0xDEAD_BEEF, rdata_valid=1, stall_o=0, hit_count=1.
- Load word 0x0000_0020 miss; mem_ready after 3 MEM_READ cycles with 0x1234_5678 -> stall_o high 4 cycles. Next cycle FILL: rdata_o=0x1234_5678, cache_fill=1, cache_fill_addr=0x20, miss_count=1.
- Byte load 0x0000_0023 miss, mem_rdata=0x0000_0042 -> rdata_o=0x42 in FILL, cache_fill=0, miss_count increments.
- Store 0xCAFE_0001 to 0x0000_0010 with cache_hit=1, mem_ready on 2nd MEM_WRITE cycle -> cache_inval pulse in IDLE cycle. mem_we=1, mem_wdata held stable 2 cycles, stall_o low in the mem_ready cycle. Counters unchanged.
- rst asserted during MEM_READ -> mem_req, stall_o, rdata_valid low immediately. Counters 0, state IDLE. A following hit load completes normally.
- Load miss immediately followed by a hit load -> FILL cycle, then hit served in the next cycle with no extra stall.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory refill controller.
package dmem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMemRead,
    StFill,
    StMemWrite
  } state_e;

  localparam logic MEM_WORD = 1'b0;
  localparam logic MEM_BYTE = 1'b1;

  // Only naturally aligned word loads may be written into the word-granular cache.
  function automatic logic fill_ok(input logic mem_type, input logic [1:0] addr_lsb);
    return (mem_type != MEM_BYTE) && (addr_lsb == 2'b00);
  endfunction

endpackage

// File: rtl/perf_counter.sv
// Free-running event counter with enable; wraps modulo 2^Width.
module perf_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + Width'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/dmem_refill_ctrl.sv
// Data-memory access controller: zero-latency load hits, stalled miss refill and
// write-through, no-allocate stores with load hit/miss counters.
module dmem_refill_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic                  req_type,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  stall_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rdata_valid,
  input  logic                  cache_hit,
  input  logic [DATA_WIDTH-1:0] cache_data,
  output logic                  cache_fill,
  output logic                  cache_inval,
  output logic [DATA_WIDTH-1:0] cache_fill_addr,
  output logic [DATA_WIDTH-1:0] cache_fill_data,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  mem_type,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  type_q, type_d;
  logic                  hit_en, miss_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      type_q  <= MEM_WORD;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      type_q  <= type_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    rdata_d         = rdata_q;
    type_d          = type_q;
    stall_o         = 1'b0;
    rdata_o         = '0;
    rdata_valid     = 1'b0;
    cache_fill      = 1'b0;
    cache_inval     = 1'b0;
    cache_fill_addr = '0;
    cache_fill_data = '0;
    mem_req         = 1'b0;
    mem_we          = 1'b0;
    mem_type        = MEM_WORD;
    mem_addr        = '0;
    mem_wdata       = '0;
    hit_en          = 1'b0;
    miss_en         = 1'b0;

    // Outputs stay low for the whole reset pulse, not just after the next edge.
    if (!rst) begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            if (!req_we && cache_hit) begin
              rdata_o     = cache_data;
              rdata_valid = 1'b1;
              hit_en      = 1'b1;
            end else begin
              stall_o = 1'b1;
              addr_d  = req_addr;
              wdata_d = req_wdata;
              type_d  = req_type;
              if (req_we) begin
                state_d = StMemWrite;
                if (cache_hit) begin
                  cache_inval     = 1'b1;
                  cache_fill_addr = req_addr;
                end
              end else begin
                miss_en = 1'b1;
                state_d = StMemRead;
              end
            end
          end
        end
        StMemRead: begin
          stall_o = 1'b1;
          mem_req = 1'b1;
          if (mem_ready) begin
            rdata_d = mem_rdata;
            state_d = StFill;
          end
        end
        StFill: begin
          rdata_o     = rdata_q;
          rdata_valid = 1'b1;
          state_d     = StIdle;
          if (fill_ok(type_q, addr_q[1:0])) begin
            cache_fill      = 1'b1;
            cache_fill_addr = addr_q;
            cache_fill_data = rdata_q;
          end
        end
        StMemWrite: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          // Release the pipeline in the completion cycle so the next access lands in IDLE.
          stall_o = !mem_ready;
          if (mem_ready) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase

      if (mem_req) begin
        mem_type  = type_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
      end
    end
  end

  perf_counter #(
    .Width(CNT_WIDTH)
  ) u_hit_counter (
    .clk_i  (clk),
    .rst_i  (rst),
    .en_i   (hit_en),
    .count_o(hit_count)
  );

  perf_counter #(
    .Width(CNT_WIDTH)
  ) u_miss_counter (
    .clk_i  (clk),
    .rst_i  (rst),
    .en_i   (miss_en),
    .count_o(miss_count)
  );

endmodule
